// File: rtl/note_tone_gen_if.sv
// ============================================================================
// Module  : note_tone_gen_if
// Brief   : Note request / speaker output bundle for the square-wave tone generator.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface note_tone_gen_if #(
    parameter int W = 27
);
    logic [W-1:0] note;
    logic         enable;
    logic         audio_out;
    logic         note_active;
    logic         note_changed;

    modport master (
        output note,
        output enable,
        input  audio_out,
        input  note_active,
        input  note_changed
    );

    modport slave (
        input  note,
        input  enable,
        output audio_out,
        output note_active,
        output note_changed
    );
endinterface

`default_nettype wire

// File: rtl/note_tone_gen.sv
// ============================================================================
// Module  : note_tone_gen
// Brief   : Glitch-free square-wave tone generator; note is a half-period in clk cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module note_tone_gen #(
    parameter int W        = 27,
    parameter int MIN_HALF = 2
) (
    input  logic            clk,
    input  logic            reset,
    note_tone_gen_if.slave  bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t       state, state_nx;
    logic [W-1:0] note_q, note_q_nx;
    logic [W-1:0] cnt, cnt_nx;
    logic [W-1:0] note_clamped;
    logic         audio, audio_nx;
    logic         changed, changed_nx;

    always_comb begin
        note_clamped = bus.note;
        if (bus.note != '0 && bus.note < W'(MIN_HALF))
            note_clamped = W'(MIN_HALF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            note_q  <= '0;
            cnt     <= '0;
            audio   <= 1'b0;
            changed <= 1'b0;
        end else begin
            state   <= state_nx;
            note_q  <= note_q_nx;
            cnt     <= cnt_nx;
            audio   <= audio_nx;
            changed <= changed_nx;
        end
    end

    // Mute outranks the boundary logic; a note change is only looked at when cnt hits 0.
    always_comb begin
        state_nx   = state;
        note_q_nx  = note_q;
        cnt_nx     = cnt;
        audio_nx   = audio;
        changed_nx = 1'b0;
        if (!bus.enable) begin
            state_nx  = IDLE;
            note_q_nx = '0;
            cnt_nx    = '0;
            audio_nx  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.note != '0) begin
                        state_nx   = PLAY;
                        note_q_nx  = note_clamped;
                        cnt_nx     = note_clamped - W'(1);
                        audio_nx   = 1'b1;
                        changed_nx = 1'b1;
                    end
                end
                PLAY: begin
                    if (cnt != '0) begin
                        cnt_nx = cnt - W'(1);
                    end else if (bus.note == '0) begin
                        state_nx  = IDLE;
                        note_q_nx = '0;
                        audio_nx  = 1'b0;
                    end else begin
                        audio_nx = ~audio;
                        cnt_nx   = note_clamped - W'(1);
                        if (note_clamped != note_q) begin
                            note_q_nx  = note_clamped;
                            changed_nx = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    assign bus.audio_out    = audio;
    assign bus.note_active  = (state == PLAY);
    assign bus.note_changed = changed;

endmodule

`default_nettype wire

// File: tb/tb_note_tone_gen.sv
// ============================================================================
// Module  : tb_note_tone_gen
// Brief   : Directed scenarios plus random stimulus against a phase-age tone model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_note_tone_gen;
    localparam int W = 27;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   check_on = 1'b0;

    note_tone_gen_if #(.W(W)) bus ();

    note_tone_gen #(.W(W), .MIN_HALF(2)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: a phase lasts 'half' cycles; 'age' counts cycles already spent in it.
    longint unsigned m_half, m_age;
    bit m_play, m_level, m_chg;

    function automatic longint unsigned clampf(input longint unsigned n);
        return (n != 0 && n < 2) ? 64'd2 : n;
    endfunction

    initial begin
        m_half = 0; m_age = 0; m_play = 0; m_level = 0; m_chg = 0;
    end

    always @(posedge clk) begin
        longint unsigned n;
        n = longint'(bus.note);
        m_chg = 0;
        if (rst || !bus.enable) begin
            m_play = 0; m_level = 0; m_half = 0; m_age = 0;
        end else if (!m_play) begin
            if (n != 0) begin
                m_play = 1; m_level = 1; m_half = clampf(n); m_age = 1; m_chg = 1;
            end
        end else if (m_age < m_half) begin
            m_age++;
        end else if (n == 0) begin
            m_play = 0; m_level = 0; m_half = 0; m_age = 0;
        end else begin
            m_level = !m_level;
            m_age   = 1;
            m_chg   = (clampf(n) != m_half);
            m_half  = clampf(n);
        end
    end

    always @(negedge clk) begin
        if (check_on) begin
            n_checks++;
            if ({bus.audio_out, bus.note_active, bus.note_changed} !== {m_level, m_play, m_chg}) begin
                n_fail++;
                $display("FAIL cycle_model @%0t: got audio=%b active=%b changed=%b, expected audio=%b active=%b changed=%b",
                         $time, bus.audio_out, bus.note_active, bus.note_changed, m_level, m_play, m_chg);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Samples n negedges; optionally rewrites note right after sample index chg_at.
    task automatic capture(input int n, input int chg_at, input logic [W-1:0] chg_val,
                           output logic [63:0] aud, output logic [63:0] act,
                           output int pulses, output int highs);
        aud = '0; act = '0; pulses = 0; highs = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            aud = {aud[62:0], bus.audio_out};
            act = {act[62:0], bus.note_active};
            if (bus.note_changed === 1'b1) pulses++;
            if (bus.audio_out === 1'b1) highs++;
            if (i == chg_at) bus.note = chg_val;
        end
    endtask

    initial begin
        logic [63:0] aud, act;
        int pulses, highs;

        rst = 1'b1; bus.enable = 1'b0; bus.note = '0;
        @(posedge clk); #1 check_on = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {61'd0, bus.audio_out, bus.note_active, bus.note_changed}, 64'd0);

        // T1: steady note 5
        rst = 1'b0; bus.enable = 1'b1; bus.note = 27'd5;
        capture(20, -1, '0, aud, act, pulses, highs);
        chk("t1_wave", aud, 64'b11111000001111100000);
        chk("t1_pulses", 64'(pulses), 64'd1);

        // T2: change to 8 two cycles into a high phase
        capture(24, 1, 27'd8, aud, act, pulses, highs);
        chk("t2_wave", aud, 64'b111110000000011111111000);
        chk("t2_pulses", 64'(pulses), 64'd1);

        // T3: rest mid-phase
        bus.note = '0;
        capture(10, -1, '0, aud, act, pulses, highs);
        chk("t3_active", act, 64'b1111100000);
        chk("t3_audio", aud, 64'd0);

        // T4: note 1 clamps to 2, then 5 repeated at every boundary
        bus.note = 27'd1;
        capture(12, -1, '0, aud, act, pulses, highs);
        chk("t4_wave_clamped", aud, 64'b110011001100);
        chk("t4_pulses_clamped", 64'(pulses), 64'd1);
        bus.note = 27'd5;
        capture(30, -1, '0, aud, act, pulses, highs);
        chk("t4_wave_5", aud, 64'b111110000011111000001111100000);
        chk("t4_pulses_5", 64'(pulses), 64'd1);

        // T5: mute for 3 cycles, then resume
        bus.enable = 1'b0;
        capture(3, -1, '0, aud, act, pulses, highs);
        chk("t5_mute_audio", aud, 64'd0);
        chk("t5_mute_active", act, 64'd0);
        bus.enable = 1'b1;
        capture(10, -1, '0, aud, act, pulses, highs);
        chk("t5_restart_wave", aud, 64'b1111100000);
        chk("t5_restart_pulses", 64'(pulses), 64'd1);

        // T6: largest note, reset mid-phase, then a long phase with no wrap
        bus.note = 27'h7FF_FFFF;
        capture(5, -1, '0, aud, act, pulses, highs);
        chk("t6_big_start", aud, 64'b11111);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_reset_outputs", {61'd0, bus.audio_out, bus.note_active, bus.note_changed}, 64'd0);
        rst = 1'b0;
        capture(200, -1, '0, aud, act, pulses, highs);
        chk("t6_big_highs", 64'(highs), 64'd200);
        chk("t6_big_pulses", 64'(pulses), 64'd1);

        // Random traffic checked only by the model
        rst = 1'b1; bus.enable = 1'b1; bus.note = '0;
        @(negedge clk);
        for (int c = 0; c < 4000; c++) begin
            int k;
            rst = ($urandom_range(0, 299) == 0);
            bus.enable = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 5) == 0) begin
                k = $urandom_range(0, 19);
                if (k < 2)       bus.note = '0;
                else if (k < 6)  bus.note = W'($urandom_range(1, 3));
                else if (k < 19) bus.note = W'($urandom_range(1, 16));
                else if ($urandom_range(0, 50) == 0) bus.note = 27'h7FF_FFFF;
                else             bus.note = W'($urandom_range(17, 60));
            end
            @(negedge clk);
        end

        check_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
